// File: rtl/gfx_rect_addr_walker_if.sv
// Command and pixel-stream bundle for the rectangle address walker.
//   The names carry the walker's view: *_i are driven by the controller or consumer, *_o by the walker.
//   slave  : the walker itself.
//   master : the register-file or sequencer side that launches walks and consumes pixel beats.
interface gfx_rect_addr_walker_if #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16
);
  logic               start_i;
  logic               abort_i;
  logic [ADDR_W-1:0]  base_i;
  logic [COORD_W-1:0] width_i;
  logic [2:0]         depth_i;
  logic [COORD_W-1:0] x0_i;
  logic [COORD_W-1:0] y0_i;
  logic [COORD_W-1:0] x1_i;
  logic [COORD_W-1:0] y1_i;
  logic               ready_i;
  logic [ADDR_W-1:0]  addr_o;
  logic [4:0]         bit_o;
  logic [COORD_W-1:0] x_o;
  logic [COORD_W-1:0] y_o;
  logic               valid_o;
  logic               last_o;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  start_i, abort_i, base_i, width_i, depth_i, x0_i, y0_i, x1_i, y1_i, ready_i,
    output addr_o, bit_o, x_o, y_o, valid_o, last_o, busy_o, err_o
  );

  modport master (
    output start_i, abort_i, base_i, width_i, depth_i, x0_i, y0_i, x1_i, y1_i, ready_i,
    input  addr_o, bit_o, x_o, y_o, valid_o, last_o, busy_o, err_o
  );
endinterface

// File: rtl/gfx_rect_addr_walker.sv
// Rectangle pixel-address walker: walks [x0..x1]x[y0..y1] row-major, one pixel per accepted beat,
// producing byte address, sub-byte bit offset and pixel coordinates for 1/2/4/8/16/24/32 bpp targets.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    gfx_rect_addr_walker_if.slave: start/abort, latched walk parameters (base, width, depth,
//          corners), pixel stream (addr/bit/x/y/valid/last with ready), busy and err status.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs valid/last low
// ST_SETUP | one cycle: the single multiply y0*width+x0, empty-rect check
// ST_WALK  | presenting pixels; advance on valid&ready, leave after last
module gfx_rect_addr_walker #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  gfx_rect_addr_walker_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WALK  = 2'd2;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [COORD_W-1:0] r_width;
  logic [2:0]         r_depth;
  logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
  logic [COORD_W-1:0] r_x, r_y;
  logic [ADDR_W-1:0]  r_lin, r_row_lin;
  logic [ADDR_W-1:0]  r_addr;
  logic [4:0]         r_bit;
  logic               r_valid, r_last, r_err;

  logic               w_idle_start, w_start_ok, w_start_bad;
  logic               w_accept, w_empty, w_load;
  logic [ADDR_W-1:0]  w_width_ext, w_setup_lin;
  logic [ADDR_W-1:0]  w_lin_nxt, w_row_nxt;
  logic [COORD_W-1:0] w_x_nxt, w_y_nxt;
  logic [ADDR_W-1:0]  w_off;
  logic [4:0]         w_bit_nxt;

  assign w_idle_start = (r_state == ST_IDLE) & bus.start_i & ~bus.abort_i;
  assign w_start_ok   = w_idle_start & (bus.depth_i != 3'd7);
  assign w_start_bad  = w_idle_start & (bus.depth_i == 3'd7);
  assign w_accept     = r_valid & bus.ready_i;
  assign w_empty      = (r_x0 > r_x1) | (r_y0 > r_y1);
  assign w_width_ext  = ADDR_W'(r_width);
  assign w_setup_lin  = ADDR_W'(r_y0) * w_width_ext + ADDR_W'(r_x0);

  // Position registers load on entry to WALK and on every non-final accepted beat.
  assign w_load = ~bus.abort_i &
                  (((r_state == ST_SETUP) & ~w_empty) |
                   ((r_state == ST_WALK) & w_accept & ~r_last));

  always_comb begin
    w_lin_nxt = r_lin;
    w_row_nxt = r_row_lin;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_state == ST_SETUP) begin
      w_lin_nxt = w_setup_lin;
      w_row_nxt = w_setup_lin;
      w_x_nxt   = r_x0;
      w_y_nxt   = r_y0;
    end else if (r_x != r_x1) begin
      w_lin_nxt = r_lin + 1'b1;
      w_x_nxt   = r_x + 1'b1;
    end else begin
      // Row wrap: next row starts exactly one target row below the current row's start.
      w_lin_nxt = r_row_lin + w_width_ext;
      w_row_nxt = r_row_lin + w_width_ext;
      w_x_nxt   = r_x0;
      w_y_nxt   = r_y + 1'b1;
    end
  end

  // Address is registered from the next linear index so it lines up with valid_o.
  always_comb begin
    w_off     = w_lin_nxt;
    w_bit_nxt = 5'd0;
    case (r_depth)
      3'd0: w_off = w_lin_nxt;
      3'd1: w_off = w_lin_nxt << 1;
      3'd2: w_off = (w_lin_nxt << 1) + w_lin_nxt;
      3'd3: w_off = w_lin_nxt << 2;
      3'd4: begin
        w_off     = w_lin_nxt >> 3;
        w_bit_nxt = {2'b00, w_lin_nxt[2:0]};
      end
      3'd5: begin
        w_off     = w_lin_nxt >> 2;
        w_bit_nxt = {2'b00, w_lin_nxt[1:0], 1'b0};
      end
      3'd6: begin
        w_off     = w_lin_nxt >> 1;
        w_bit_nxt = {2'b00, w_lin_nxt[0], 2'b00};
      end
      default: w_off = w_lin_nxt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_width   <= '0;
      r_depth   <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_lin     <= '0;
      r_row_lin <= '0;
      r_addr    <= '0;
      r_bit     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_start_bad;

      if (w_load) begin
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_lin     <= w_lin_nxt;
        r_row_lin <= w_row_nxt;
        r_addr    <= r_base + w_off;
        r_bit     <= w_bit_nxt;
        r_valid   <= 1'b1;
        r_last    <= (w_x_nxt == r_x1) & (w_y_nxt == r_y1);
      end

      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          if (w_start_ok) begin
            r_base  <= bus.base_i;
            r_width <= bus.width_i;
            r_depth <= bus.depth_i;
            r_x0    <= bus.x0_i;
            r_y0    <= bus.y0_i;
            r_x1    <= bus.x1_i;
            r_y1    <= bus.y1_i;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (bus.abort_i || w_empty) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (bus.abort_i || (w_accept && r_last)) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_o  = r_addr;
  assign bus.bit_o   = r_bit;
  assign bus.x_o     = r_x;
  assign bus.y_o     = r_y;
  assign bus.valid_o = r_valid;
  assign bus.last_o  = r_last;
  assign bus.busy_o  = (r_state != ST_IDLE);
  assign bus.err_o   = r_err;
endmodule

// File: tb/tb_gfx_rect_addr_walker.sv
module tb_gfx_rect_addr_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] q_addr[$];
  logic [4:0]  q_bit[$];

  always #5 clk = ~clk;

  gfx_rect_addr_walker_if #(.ADDR_W(32), .COORD_W(16)) bus();

  gfx_rect_addr_walker #(.ADDR_W(32), .COORD_W(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [31:0] base, input logic [15:0] width, input logic [2:0] depth,
                         input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1);
    bus.base_i  = base;
    bus.width_i = width;
    bus.depth_i = depth;
    bus.x0_i    = x0;
    bus.y0_i    = y0;
    bus.x1_i    = x1;
    bus.y1_i    = y1;
  endtask

  // Launches a walk with ready held high and checks every beat against q_addr/q_bit plus the
  // row-major coordinate order; command inputs are scrambled after start to prove they are latched.
  task automatic walk(input string tag, input logic [31:0] base, input logic [15:0] width,
                      input logic [2:0] depth, input logic [15:0] x0, input logic [15:0] y0,
                      input logic [15:0] x1, input logic [15:0] y1);
    int n;
    int k;
    logic [15:0] ex;
    logic [15:0] ey;
    n  = q_addr.size();
    k  = 0;
    ex = x0;
    ey = y0;
    bus.ready_i = 1'b1;
    set_cmd(base, width, depth, x0, y0, x1, y1);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    set_cmd(~base, width + 16'd3, 3'd1, x0 + 16'd7, y0 + 16'd5, x1 + 16'd9, y1 + 16'd2);
    chk({tag, " setup busy"}, bus.busy_o, 1'b1);
    chk({tag, " setup valid"}, bus.valid_o, 1'b0);
    for (int c = 0; c < 64; c++) begin
      step();
      if (c == 0) chk({tag, " first valid latency"}, bus.valid_o, 1'b1);
      if (!bus.busy_o) break;
      if (bus.valid_o) begin
        if (k < n) begin
          chk($sformatf("%s beat%0d addr", tag, k), bus.addr_o, q_addr[k]);
          chk($sformatf("%s beat%0d bit", tag, k), bus.bit_o, q_bit[k]);
          chk($sformatf("%s beat%0d x", tag, k), bus.x_o, ex);
          chk($sformatf("%s beat%0d y", tag, k), bus.y_o, ey);
          chk($sformatf("%s beat%0d last", tag, k), bus.last_o, (k == n - 1));
        end
        k++;
        if (ex == x1) begin
          ex = x0;
          ey = ey + 16'd1;
        end else begin
          ex = ex + 16'd1;
        end
      end
    end
    chk({tag, " beat count"}, k, n);
    chk({tag, " idle after"}, bus.busy_o, 1'b0);
    chk({tag, " valid after"}, bus.valid_o, 1'b0);
    q_addr.delete();
    q_bit.delete();
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.ready_i = 1'b1;
    set_cmd(32'd0, 16'd0, 3'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset valid", bus.valid_o, 1'b0);
    chk("reset busy", bus.busy_o, 1'b0);
    chk("reset err", bus.err_o, 1'b0);
    chk("reset last", bus.last_o, 1'b0);
    chk("reset addr", bus.addr_o, 32'd0);

    // 8bpp, width 640: row 1 starts at lin 642 (0x282), row 2 at 1282 (0x502).
    q_addr = '{32'h1282, 32'h1283, 32'h1284, 32'h1502, 32'h1503, 32'h1504};
    q_bit  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    walk("bpp8", 32'h1000, 16'd640, 3'd0, 16'd2, 16'd1, 16'd4, 16'd2);

    q_addr = '{32'd3, 32'd6};  q_bit = '{5'd0, 5'd0};
    walk("bpp24", 32'd0, 16'd100, 3'd2, 16'd1, 16'd0, 16'd2, 16'd0);
    q_addr = '{32'd4, 32'd8};  q_bit = '{5'd0, 5'd0};
    walk("bpp32", 32'd0, 16'd100, 3'd3, 16'd1, 16'd0, 16'd2, 16'd0);
    q_addr = '{32'd2, 32'd4};  q_bit = '{5'd0, 5'd0};
    walk("bpp16", 32'd0, 16'd100, 3'd1, 16'd1, 16'd0, 16'd2, 16'd0);

    q_addr = '{32'h200, 32'h200, 32'h201, 32'h201};
    q_bit  = '{5'd6, 5'd7, 5'd0, 5'd1};
    walk("bpp1", 32'h200, 16'd16, 3'd4, 16'd6, 16'd0, 16'd9, 16'd0);
    q_addr = '{32'h200, 32'h201};  q_bit = '{5'd4, 5'd0};
    walk("bpp4", 32'h200, 16'd16, 3'd6, 16'd1, 16'd0, 16'd2, 16'd0);
    // 2bpp row 1 of width 16: lin 19 -> byte 4 bit 6, lin 20 -> byte 5 bit 0.
    q_addr = '{32'h204, 32'h205};  q_bit = '{5'd6, 5'd0};
    walk("bpp2", 32'h200, 16'd16, 3'd5, 16'd3, 16'd1, 16'd4, 16'd1);

    q_addr = '{32'h50A};  q_bit = '{5'd0};
    walk("single", 32'h500, 16'd8, 3'd0, 16'd2, 16'd1, 16'd2, 16'd1);

    // Backpressure: ready 1,0,0,1 across the first two beats.
    set_cmd(32'd0, 16'd10, 3'd0, 16'd0, 16'd0, 16'd3, 16'd0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    chk("bp beat0 addr", bus.addr_o, 32'd0);
    step();
    chk("bp beat1 addr", bus.addr_o, 32'd1);
    bus.ready_i = 1'b0;
    step();
    chk("bp hold1 addr", bus.addr_o, 32'd1);
    chk("bp hold1 x", bus.x_o, 16'd1);
    chk("bp hold1 valid", bus.valid_o, 1'b1);
    step();
    chk("bp hold2 addr", bus.addr_o, 32'd1);
    chk("bp hold2 last", bus.last_o, 1'b0);
    bus.ready_i = 1'b1;
    step();
    chk("bp beat2 addr", bus.addr_o, 32'd2);
    step();
    chk("bp beat3 addr", bus.addr_o, 32'd3);
    chk("bp beat3 last", bus.last_o, 1'b1);
    step();
    chk("bp end busy", bus.busy_o, 1'b0);

    // Empty rectangle: SETUP then straight back to IDLE without a beat.
    set_cmd(32'd0, 16'd10, 3'd0, 16'd5, 16'd0, 16'd3, 16'd0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("empty busy1", bus.busy_o, 1'b1);
    chk("empty valid1", bus.valid_o, 1'b0);
    step();
    chk("empty busy2", bus.busy_o, 1'b0);
    chk("empty valid2", bus.valid_o, 1'b0);

    // Illegal depth: err pulse for one cycle, never busy.
    set_cmd(32'd0, 16'd10, 3'd7, 16'd0, 16'd0, 16'd3, 16'd0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("depth7 err", bus.err_o, 1'b1);
    chk("depth7 busy", bus.busy_o, 1'b0);
    step();
    chk("depth7 err clear", bus.err_o, 1'b0);

    // 10x10 walk: start while busy is ignored, abort on the 3rd beat.
    set_cmd(32'd0, 16'd10, 3'd0, 16'd0, 16'd0, 16'd9, 16'd9);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    step();
    chk("abort beat1 addr", bus.addr_o, 32'd1);
    bus.start_i = 1'b1;
    bus.x0_i    = 16'd5;
    step();
    bus.start_i = 1'b0;
    chk("busy start ignored x", bus.x_o, 16'd2);
    chk("abort beat2 addr", bus.addr_o, 32'd2);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("abort valid", bus.valid_o, 1'b0);
    chk("abort busy", bus.busy_o, 1'b0);
    bus.x0_i    = 16'd0;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("abort beats start", bus.busy_o, 1'b0);
    step();
    bus.start_i = 1'b0;
    chk("restart busy", bus.busy_o, 1'b1);
    step();
    chk("restart valid", bus.valid_o, 1'b1);
    chk("restart addr", bus.addr_o, 32'd0);
    chk("restart x", bus.x_o, 16'd0);
    chk("restart y", bus.y_o, 16'd0);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("final abort busy", bus.busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
